// File: rtl/fpu_ss_mem_tracker.sv
// Metadata tracker for FP loads/stores offloaded over the X-interface memory channel.
// Holds {rd, we, id} per outstanding request and presents the oldest until its result returns.
module fpu_ss_mem_tracker #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [4:0]                   push_rd_i,
  input  logic                         push_we_i,
  input  logic [ID_WIDTH-1:0]          push_id_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [4:0]                   pop_rd_o,
  output logic                         pop_we_o,
  output logic [ID_WIDTH-1:0]          pop_id_o,
  input  logic                         result_err_i,
  input  logic                         flush_i,
  output logic                         err_o,
  output logic [ID_WIDTH-1:0]          err_id_o,
  output logic                         underflow_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0]          rd;
    logic                we;
    logic [ID_WIDTH-1:0] id;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;
  logic [ID_WIDTH-1:0] err_id_q;
  logic               underflow_q;
  logic               do_push;
  logic               do_pop;

  assign push_ready_o = (count_q != CNT_W'(DEPTH));
  assign pop_valid_o  = (count_q != CNT_W'(0));
  assign do_push      = push_valid_i & push_ready_o;
  assign do_pop       = pop_ready_i & pop_valid_o;

  assign pop_rd_o     = mem[rd_ptr].rd;
  assign pop_we_o     = mem[rd_ptr].we;
  assign pop_id_o     = mem[rd_ptr].id;
  assign count_o      = count_q;
  assign err_o        = err_q;
  assign err_id_o     = err_id_q;
  assign underflow_o  = underflow_q;

  // Entry storage carries no reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) begin
      mem[wr_ptr] <= '{rd: push_rd_i, we: push_we_i, id: push_id_i};
    end
  end

  // Pointers and occupancy; flush wins over same-cycle push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error capture keeps the id of the first failing result only.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      err_q       <= 1'b0;
      err_id_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (do_pop && result_err_i && !err_q) begin
        err_q    <= 1'b1;
        err_id_q <= mem[rd_ptr].id;
      end
      if (pop_ready_i && !pop_valid_o) underflow_q <= 1'b1;
    end
  end

endmodule

// File: doc/fpu_ss_mem_tracker.md
Name: fpu_ss_mem_tracker

Overview:
- Tracks every FP load/store the FPU subsystem controller offloads to the core over the X-interface memory request channel.
- Receives metadata (destination FPR, write-enable, instruction id) on each accepted memory request.
- Presents metadata for the oldest outstanding request until the matching memory result arrives.
- Sits between the controller's mem_push/mem_pop handshakes and the FP register-file writeback/forwarding path. Also reports occupancy and latches bus errors.

Parameters:
- DEPTH, 4, number of outstanding memory requests tracked; power of two, at least 2.
- ID_WIDTH, 4, width of the X-interface instruction id.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- push_valid_i  in  1  memory request handshake completed this cycle (controller mem_push_valid).
- push_ready_o  out  1  space available (controller mem_push_ready).
- push_rd_i  in  5  destination FPR of the request.
- push_we_i  in  1  request writes the FPR file (load=1, store=0).
- push_id_i  in  ID_WIDTH  instruction id of the request.
- pop_valid_o  out  1  oldest entry valid.
- pop_ready_i  in  1  memory result consumed (controller mem_pop_ready = x_mem_result_valid).
- pop_rd_o  out  5  oldest entry rd.
- pop_we_o  out  1  oldest entry we.
- pop_id_o  out  ID_WIDTH  oldest entry id.
- result_err_i  in  1  X-interface memory result error, qualified by pop_ready_i.
- flush_i  in  1  discard all entries (killed memory sequence).
- err_o  out  1  sticky bus-error flag.
- err_id_o  out  ID_WIDTH  id of first erroring request.
- underflow_o  out  1  sticky flag: pop_ready_i while empty.
- count_o  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: circular buffer of DEPTH entries {rd, we, id}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy counter is held in count_o.
- Reset, when rst_i is sampled high at a clock edge:
  - pointers, count_o, err_o, err_id_o and underflow_o all go to 0.
  - push_ready_o=1, pop_valid_o=0.
  - Entry storage is not reset.
  - Reset mid-operation drops all outstanding entries.
- push_ready_o = (count_o != DEPTH). It is purely registered-state derived, with no combinational dependence on pop_ready_i. A full buffer therefore refuses a push even in a cycle that also pops.
- Push occurs when push_valid_i & push_ready_o. The entry is written at the write pointer and the pointer is incremented. push_valid_i while full: ignored, no state change.
- pop_valid_o = (count_o != 0).
  - pop_* outputs reflect the entry at the read pointer combinationally from storage.
  - Outputs are undefined-but-stable when empty; the bench must not check them when pop_valid_o=0.
- Pop occurs when pop_ready_i & pop_valid_o, and increments the read pointer.
- Latency:
  - A pushed entry is visible on pop_* the cycle after the push. There is no same-cycle bypass; the core never returns a result in the request cycle.
  - Pop takes effect at the clock edge; the next entry is visible the following cycle.
- Simultaneous push and pop with 0 < count_o < DEPTH: both happen and count_o is unchanged.
  - Push and pop when count_o=0: push only, pop ignored, underflow_o set.
- Errors:
  - On pop with result_err_i=1 and err_o=0: err_o<=1 and err_id_o<=pop_id_o.
  - Later errors leave err_id_o unchanged.
  - err_o and underflow_o clear only on rst_i or flush_i.
- Flush: flush_i=1 has priority over push and pop in the same cycle. Pointers and count go to 0, err_o/underflow_o clear, and err_id_o goes to 0.
- count_o stays in the range 0..DEPTH at all times.

Test Plan:
- Reset, then push rd=3 we=1 id=5 -> next cycle pop_valid_o=1, pop_rd_o=3, pop_we_o=1, pop_id_o=5, count_o=1. Pop -> count_o=0, pop_valid_o=0.
- Push 4 entries (ids 0..3, DEPTH=4) -> count_o=4, push_ready_o=0. A fifth push with id=9 is ignored. Pops then return ids 0,1,2,3 in order.
- Fill, pop 2, push ids 4 and 5 (write pointer wraps) -> pop order 2,3,4,5 with correct rd/we per entry.
- With count_o=2, push and pop in the same cycle for 10 cycles -> count_o stays 2 and FIFO order is preserved.
- Pop id=7 with result_err_i=1, then pop id=8 with result_err_i=1 -> err_o=1, err_id_o=7. flush_i -> err_o=0, count_o=0.
- pop_ready_i while empty -> underflow_o=1, count_o=0. Assert rst_i with 3 entries held -> next cycle count_o=0, pop_valid_o=0, underflow_o=0.
